// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative radix-2 RV32M multiply/divide unit with valid/ready handshake
// Ports: clk, rst (sync, active-high); in_valid/in_ready, A, B, op (funct3) operation input;
//   out_valid/out_ready, Result, Zero result output.
// Option: define ALU_MULDIV_FAST_DIV0_EN to finish divide-by-zero and signed-overflow
//   operations one clock after accept instead of iterating.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
);
  localparam int CW = $clog2(WIDTH);
`ifdef ALU_MULDIV_FAST_DIV0_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state_q;
  logic [WIDTH-1:0] hi_q, lo_q, opb_q, spec_res_q, result_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] op_q;
  logic neg_q, spec_q, in_ready_q, out_valid_q, zero_q;
  logic a_neg, b_neg, spec_d, neg_d, ge, last;
  logic [WIDTH-1:0] a_mag, b_mag, spec_res_d, div_v, diff, fin;
  logic [WIDTH:0] mul_sum, shifted;
  logic [2*WIDTH-1:0] prod;
  // Magnitudes stay WIDTH bits: the most-negative value maps to 2^(WIDTH-1) as unsigned.
  // hi/lo hold {product} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    a_neg = A[WIDTH-1] & (op[2] ? ~op[0] : ~(op[1] & op[0]));
    b_neg = B[WIDTH-1] & (op[2] ? ~op[0] : ~op[1]);
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;
    spec_d = op[2] & ((B == '0) | (~op[0] & (A == {1'b1, {(WIDTH-1){1'b0}}}) & (B == '1)));
    spec_res_d = (B == '0) ? (op[1] ? A : '1) : (op[1] ? '0 : A);
    neg_d = (op[2] & op[1]) ? a_neg : a_neg ^ b_neg;
    mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opb_q : {WIDTH{1'b0}})};
    shifted = {hi_q, lo_q[WIDTH-1]};
    ge = shifted >= {1'b0, opb_q};
    diff = shifted[WIDTH-1:0] - opb_q;
    last = cnt_q == CW'(WIDTH - 1);
    prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    div_v = op_q[1] ? hi_q : lo_q;
    fin = spec_q ? spec_res_q :
          op_q[2] ? (neg_q ? -div_v : div_v) :
          (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      result_q <= '0;
      zero_q <= 1'b0;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      opb_q <= '0;
      op_q <= '0;
      neg_q <= 1'b0;
      spec_q <= 1'b0;
      spec_res_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_q <= op;
          neg_q <= neg_d;
          spec_q <= spec_d;
          spec_res_q <= spec_res_d;
          hi_q <= '0;
          lo_q <= op[2] ? a_mag : b_mag;
          opb_q <= op[2] ? b_mag : a_mag;
          cnt_q <= '0;
          in_ready_q <= 1'b0;
          state_q <= (FAST && spec_d) ? DONE : op[2] ? DIV : MUL;
        end
        MUL: begin
          {hi_q, lo_q} <= {mul_sum, lo_q[WIDTH-1:1]};
          cnt_q <= last ? '0 : cnt_q + CW'(1);
          if (last) state_q <= DONE;
        end
        DIV: begin
          hi_q <= ge ? diff : shifted[WIDTH-1:0];
          lo_q <= {lo_q[WIDTH-2:0], ge};
          cnt_q <= last ? '0 : cnt_q + CW'(1);
          if (last) state_q <= DONE;
        end
        DONE: if (!out_valid_q) begin
          // First DONE cycle applies sign correction and registers the result.
          result_q <= fin;
          zero_q <= fin == '0;
          out_valid_q <= 1'b1;
        end else if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign Result = result_q;
  assign Zero = zero_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: scoreboard bench for alu_muldiv_seq (WIDTH=32)
module tb_alu_muldiv_seq;
  localparam int LAT = 33;
`ifdef ALU_MULDIV_FAST_DIV0_EN
  localparam int SLAT = 1;
`else
  localparam int SLAT = 33;
`endif
  typedef struct {
    logic [31:0] res;
    logic        zero;
    int          lat;
    int          acc;
  } exp_t;
  logic clk = 1'b0, rst, in_valid, in_ready, out_valid, out_ready, Zero;
  logic [31:0] A, B, Result;
  logic [2:0] op;
  int checks = 0, errors = 0, cyc = 0;
  exp_t q[$];
  exp_t e;
  logic ov_prev = 1'b0;
  alu_muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .Result(Result), .Zero(Zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o);
    longint sa, sb, ub, p;
    logic [63:0] pu;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    pu = {32'b0, a} * {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = 0;
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: return pu[63:32];
      3'd4: begin p = sa / sb; return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : p[31:0]; end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin p = sa % sb; return (b == 0) ? a : ovf ? 32'h0 : p[31:0]; end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction
  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o);
    return (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? SLAT : LAT;
  endfunction
  always @(negedge clk) begin
    if (out_valid && !ov_prev) begin
      if (q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("result", Result, e.res);
        chk("zero", Zero, e.zero);
        chk("latency", cyc - e.acc, e.lat);
      end
    end
    ov_prev = out_valid;
  end
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                       input logic [31:0] res, input int lat, input bit push);
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    A = a; B = b; op = o; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) q.push_back('{res, res == 0, lat, cyc});
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask
  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                     input logic [31:0] res, input int lat);
    issue(a, b, o, res, lat, 1'b1);
    wait_valid();
    consume();
  endtask
  logic [31:0] ta [14] = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                          32'd100, 32'd14, 32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000,
                          32'hFFFF_FFFB, 32'hFFFF_FFFB};
  logic [31:0] tb_ [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                           32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
  logic [2:0] to [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
  logic [31:0] tr [14] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                          32'hFFFF_FFFF, 32'd14, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000,
                          32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
  int tl [14] = '{LAT, LAT, LAT, LAT, LAT, LAT, LAT, LAT, SLAT, SLAT, SLAT, SLAT, SLAT, SLAT};
  initial begin
    logic [31:0] ra, rb;
    logic [2:0] ro;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", Result, 0);
    chk("rst_zero", Zero, 0);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) run(ta[i], tb_[i], to[i], tr[i], tl[i]);
    for (int i = 0; i < 12; i++) begin
      ra = (i == 5) ? 32'h8000_0000 : $urandom;
      rb = (i == 5) ? 32'hFFFF_FFFF : (i % 4 == 0) ? 32'h0 : $urandom;
      ro = (i == 5) ? 3'd4 : 3'($urandom_range(0, 7));
      run(ra, rb, ro, ref_res(ra, rb, ro), ref_lat(ra, rb, ro));
    end
    issue(32'h7, 32'hFFFF_FFFD, 3'd0, 32'hFFFF_FFEB, LAT, 1'b1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin A = 32'h1; B = 32'h1; op = 3'd5; in_valid = 1'b1; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("hold_result", Result, 32'hFFFF_FFEB);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    consume();
    chk("after_in_ready", in_ready, 1);
    chk("after_out_valid", out_valid, 0);
    issue(32'd1000, 32'd3, 3'd4, 32'd0, LAT, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_output", out_valid, 0);
    run(32'd3, 32'd5, 3'd0, 32'd15, LAT);
    repeat (3) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
